// File: rtl/rvv_dispatch_trace_fifo.sv
// Dispatch trace FIFO: packs up to four fired dispatch lanes per cycle into timestamped records.
// Optional macro RVV_TRACE_DROP_CNT_EN builds the saturating dropped-cycle counter.

package RvvAxiPkg;
   typedef struct packed {
      logic [31:0]      cycles;
      logic [3:0]       dispatch_instFire;
      logic [3:0][31:0] dispatch_instAddr;
      logic [3:0][31:0] dispatch_instInst;
   } io_debug_out_t;
endpackage

// state   | meaning
// EMPTY   | level == 0, no head record
// PARTIAL | 0 < level < DEPTH
// FULL    | level == DEPTH, every non-empty dispatch cycle is dropped
module rvv_dispatch_trace_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic                                         clk_i,
   input  logic                                         rst_i,
   input  logic [$bits(RvvAxiPkg::io_debug_out_t)-1:0]  dbg_i,
   input  logic                                         trace_en_i,
   input  logic                                         flush_i,
   output logic                                         rec_valid_o,
   input  logic                                         rec_ready_i,
   output logic [31:0]                                  rec_addr_o,
   output logic [31:0]                                  rec_inst_o,
   output logic [31:0]                                  rec_cycle_o,
   output logic [1:0]                                   rec_lane_o,
   output logic [$clog2(DEPTH):0]                       level_o,
   output logic                                         overflow_o,
   output logic [CNT_W-1:0]                             drop_cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
      logic [31:0] cycle;
      logic [1:0]  lane;
   } rec_t;

   typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

   RvvAxiPkg::io_debug_out_t dbg;
   assign dbg = dbg_i;

   rec_t          mem_q [DEPTH];
   rec_t          head;
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW-1:0] level, level_d, free;
   state_t        state_q, state_d;
   logic          overflow_q;

   logic [3:0]    fire;
   logic [2:0]    n;
   logic [1:0]    slot_lane [4];
   logic [AW-1:0] wr_idx [4];
   logic          admit, push, pop, drop;

   assign fire = dbg.dispatch_instFire & {4{trace_en_i}};

   // Ascending-lane compaction: slot k takes the k-th fired lane.
   always_comb begin
      n = 3'd0;
      for (int k = 0; k < 4; k++) begin
         slot_lane[k] = 2'd0;
         wr_idx[k]    = wptr_q[AW-1:0] + AW'(k);
      end
      for (int l = 0; l < 4; l++) begin
         if (fire[l]) begin
            slot_lane[n[1:0]] = 2'(l);
            n = n + 3'd1;
         end
      end
   end

   assign level = wptr_q - rptr_q;
   assign free  = PW'(DEPTH) - level;

   // Admission uses pre-pop occupancy; a same-cycle pop earns no credit.
   assign admit = (state_q != ST_FULL) && (PW'(n) <= free);
   assign push  = !flush_i && admit && (n != 3'd0);
   assign pop   = !flush_i && rec_valid_o && rec_ready_i;
   assign drop  = !flush_i && !admit && (n != 3'd0);

   always_comb begin
      state_d = state_q;
      level_d = level;
      if (flush_i) begin
         level_d = '0;
      end else begin
         level_d = level + (push ? PW'(n) : PW'(0)) - PW'(pop);
      end
      case (state_q)
         ST_EMPTY, ST_PARTIAL, ST_FULL: begin
            if (level_d == '0)
               state_d = ST_EMPTY;
            else if (level_d == PW'(DEPTH))
               state_d = ST_FULL;
            else
               state_d = ST_PARTIAL;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_EMPTY;
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (flush_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
         end else begin
            if (push)
               wptr_q <= wptr_q + PW'(n);
            if (pop)
               rptr_q <= rptr_q + PW'(1);
            if (drop)
               overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (push) begin
         for (int k = 0; k < 4; k++) begin
            if (3'(k) < n) begin
               mem_q[wr_idx[k]] <= '{addr:  dbg.dispatch_instAddr[slot_lane[k]],
                                     inst:  dbg.dispatch_instInst[slot_lane[k]],
                                     cycle: dbg.cycles,
                                     lane:  slot_lane[k]};
            end
         end
      end
   end

`ifdef RVV_TRACE_DROP_CNT_EN
   logic [CNT_W-1:0] drop_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         drop_cnt_q <= '0;
      else if (flush_i)
         drop_cnt_q <= '0;
      else if (drop && (drop_cnt_q != '1))
         drop_cnt_q <= drop_cnt_q + CNT_W'(1);
   end

   assign drop_cnt_o = drop_cnt_q;
`else
   assign drop_cnt_o = '0;
`endif

   assign head        = mem_q[rptr_q[AW-1:0]];
   assign rec_valid_o = (state_q != ST_EMPTY);
   assign rec_addr_o  = head.addr;
   assign rec_inst_o  = head.inst;
   assign rec_cycle_o = head.cycle;
   assign rec_lane_o  = head.lane;
   assign level_o     = level;
   assign overflow_o  = overflow_q;

endmodule
